dp_selection_sort: RTL and testbench
====================================

Name: dp_selection_sort

Overview:
Datapath for the selection-sort engine, sitting directly downstream of the selection-sort control unit. It consumes the unit's present-state code and swap strobe, and returns the status flags end_load, hit_i, hit_j and end_show that drive its transitions. It holds an N-entry register array, loads it serially, sorts it in place ascending by selection sort, then streams the result out.

Parameters:
N, 8, element count; legal range 2..256.
W, 8, element width in bits; unsigned compare.
CW, $clog2(N), index/counter width (derived; not to be overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ps  in  3  CU state: 0 IDLE, 1 LOAD, 2 ANCHOR, 3 FINDMIN, 4 SHOW; 5-7 invalid.
swap  in  1  CU swap strobe; honoured only when ps==FINDMIN.
in_valid  in  1  load data qualifier.
in_data  in  W  load element.
end_load  out  1  combinational: ps==LOAD && in_valid && ld_cnt==N-1.
hit_i  out  1  combinational: ps==ANCHOR && i==N-1.
hit_j  out  1  combinational: ps==FINDMIN && j==N-1.
end_show  out  1  combinational: ps==SHOW && sh_cnt==N-1.
out_valid  out  1  registered output-element qualifier.
out_data  out  W  registered output element.

Behaviour:
- Internal state: mem[0..N-1] (W bits each); ld_cnt, i, j, min_idx, sh_cnt (CW bits each).
- Reset, asynchronous: all mem entries 0, all counters 0, out_valid 0, out_data 0. Reset mid-operation discards partial load/sort; the CU resets to IDLE on the same rst.
- IDLE: ld_cnt, i, j, min_idx, sh_cnt cleared to 0 each cycle. mem is held, so the last sorted set is retained. out_valid 0.
- LOAD: on each cycle with in_valid=1: mem[ld_cnt] <= in_data, ld_cnt++. Cycles with in_valid=0 hold all state. end_load rises in the cycle the Nth element is written. i is 0 on entry to ANCHOR.
- ANCHOR (one cycle per outer pass): min_idx <= i, j <= i+1. When i==N-1, hit_i=1, the CU moves to SHOW, and no j/min_idx update matters.
- FINDMIN (one compare per cycle):
  - cand = (mem[j] < mem[min_idx]) ? j : min_idx. Strict compare; ties keep the lower index.
  - Every cycle: min_idx <= cand, j++.
  - On a cycle with swap=1 (CU asserts it when hit_j=1): exchange mem[i] and mem[cand] in the same edge, then i <= i+1.
  - cand==i gives a no-op write.
  - swap=1 while j!=N-1 is still honoured as an immediate swap with the current cand; the bench never drives this.
- Cycle count per pass: 1 ANCHOR + (N-1-i) FINDMIN. Total sort for N=8 is 8 ANCHOR + 28 FINDMIN cycles.
- SHOW: each cycle out_data <= mem[sh_cnt], out_valid <= 1, sh_cnt++.
  - Output latency is 1 cycle from the SHOW cycle that indexes the element.
  - The last element (index N-1) appears in the first IDLE cycle, then out_valid returns to 0.
- Invalid ps (5-7): all state held, all flags 0, out_valid 0.
- Counters never wrap in legal operation. If they reach N-1 without the expected transition, they saturate at N-1.

Optional Feature:
SORT_DESCENDING_EN
- Defined: FINDMIN compare becomes mem[j] > mem[min_idx]; output is non-increasing. Ties still keep the lower index.
- Undefined: ascending (default).

Test Plan:
1. Load [5,3,7,1,8,2,6,4] with in_valid continuous, ps driven by a CU model. Required: end_load on the 8th load cycle; out_data stream 1,2,3,4,5,6,7,8 with out_valid high for exactly 8 cycles.
2. Cycle accounting, same run: exactly 8 ANCHOR and 28 FINDMIN cycles; hit_i only on the 8th ANCHOR; swap coincides with hit_j every pass.
3. Duplicates and gaps: load [2,2,0,255,0,2,255,1] with in_valid low on alternate cycles. Required: ld_cnt holds during gaps; output 0,0,1,2,2,2,255,255.
4. Pre-sorted [1..8] and reversed [8..1]. Required: both output 1..8; the pre-sorted case performs only no-op swaps, mem unchanged after each pass.
5. rst asserted mid-FINDMIN (pass i=3). Required: immediately all counters 0, mem all 0, out_valid 0. A fresh load of [9,8,7,6,5,4,3,2] then outputs 2..9.
6. With SORT_DESCENDING_EN defined, test-1 data. Required: output 8,7,6,5,4,3,2,1.

Source files
------------

// File: rtl/dp_selection_sort.sv
// dp_selection_sort: datapath of the selection-sort engine.
// Holds an N-entry register array. The array is loaded serially, sorted in
// place by selection sort under control-unit supervision, and then streamed
// out. The control unit's present state arrives on ps. The status flags
// end_load, hit_i, hit_j and end_show are returned combinationally.
// Build option: define SORT_DESCENDING_EN to sort in non-increasing order
// instead of the default ascending order.
module dp_selection_sort #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   ps,
  input  logic         swap,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         end_load,
  output logic         hit_i,
  output logic         hit_j,
  output logic         end_show,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int unsigned   CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ANCHOR  = 3'd2,
    S_FINDMIN = 3'd3,
    S_SHOW    = 3'd4
  } cu_state_t;

  logic [W-1:0]  mem [N];
  logic [CW-1:0] ld_cnt, i, j, min_idx, sh_cnt;
  logic [CW-1:0] cand;
  logic          is_idle, is_load, is_anchor, is_findmin, is_show;

  // Counters stop at the last index instead of wrapping.
  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] x);
    return (x == LAST) ? x : x + CW'(1);
  endfunction

  // Decode the control-unit state code; codes 5-7 match nothing and hold state.
  always_comb begin
    is_idle    = (ps == S_IDLE);
    is_load    = (ps == S_LOAD);
    is_anchor  = (ps == S_ANCHOR);
    is_findmin = (ps == S_FINDMIN);
    is_show    = (ps == S_SHOW);
  end

  // Running-minimum candidate. A strict compare keeps the lower index on ties.
  always_comb begin
    cand = min_idx;
`ifdef SORT_DESCENDING_EN
    if (mem[j] > mem[min_idx]) cand = j;
`else
    if (mem[j] < mem[min_idx]) cand = j;
`endif
  end

  // Status flags consumed by the control unit.
  always_comb begin
    end_load = is_load    && in_valid && (ld_cnt == LAST);
    hit_i    = is_anchor  && (i == LAST);
    hit_j    = is_findmin && (j == LAST);
    end_show = is_show    && (sh_cnt == LAST);
  end

  // Array, index counters and output register, advanced per control-unit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '{default: '0};
      ld_cnt    <= '0;
      i         <= '0;
      j         <= '0;
      min_idx   <= '0;
      sh_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (is_idle) begin
        ld_cnt  <= '0;
        i       <= '0;
        j       <= '0;
        min_idx <= '0;
        sh_cnt  <= '0;
      end else if (is_load) begin
        if (in_valid) begin
          mem[ld_cnt] <= in_data;
          ld_cnt      <= inc_sat(ld_cnt);
        end
      end else if (is_anchor) begin
        min_idx <= i;
        j       <= inc_sat(i);
      end else if (is_findmin) begin
        min_idx <= cand;
        j       <= inc_sat(j);
        // Exchange uses this cycle's candidate, so the final compare of the
        // pass and the swap happen on one edge. When cand==i, both writes
        // store the same value.
        if (swap) begin
          mem[i]    <= mem[cand];
          mem[cand] <= mem[i];
          i         <= inc_sat(i);
        end
      end else if (is_show) begin
        out_data  <= mem[sh_cnt];
        out_valid <= 1'b1;
        sh_cnt    <= inc_sat(sh_cnt);
      end
    end
  end

endmodule

// File: tb/tb_dp_selection_sort.sv
// tb_dp_selection_sort: directed self-checking bench for dp_selection_sort.
// A behavioural control-unit sequence drives ps and swap. The bench checks
// the status flags, the cycle accounting and the sorted output stream.
module tb_dp_selection_sort;

  localparam int N = 8;
  localparam int W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ANCHOR  = 3'd2,
    ST_FINDMIN = 3'd3,
    ST_SHOW    = 3'd4
  } cu_t;

  typedef logic [W-1:0] vec_t [N];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   ps = ST_IDLE;
  logic         swap = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         end_load, hit_i, hit_j, end_show, out_valid;
  logic [W-1:0] out_data;

  int errors = 0;
  int checks = 0;

  dp_selection_sort #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps       (ps),
    .swap     (swap),
    .in_valid (in_valid),
    .in_data  (in_data),
    .end_load (end_load),
    .hit_i    (hit_i),
    .hit_j    (hit_j),
    .end_show (end_show),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_load(input vec_t d, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps && k > 0) begin
        @(negedge clk); ps = ST_LOAD; in_valid = 1'b0; in_data = 8'hAA; #1;
        check("gap_end_load", 32'(end_load), 32'(0));
        check("gap_ld_cnt", 32'(dut.ld_cnt), 32'(k));
      end
      @(negedge clk); ps = ST_LOAD; in_valid = 1'b1; in_data = d[k]; #1;
      if (gaps) check("ld_cnt_after_gap", 32'(dut.ld_cnt), 32'(k));
      check("end_load", 32'(end_load), 32'(k == N - 1));
    end
  endtask

  task automatic run_sort(input int abort_pass, input bit chk_static,
                          output int anchors, output int finds, output int pass_bad);
    bit done;
    anchors = 0; finds = 0; pass_bad = 0; done = 0;
    for (int p = 0; p < N + 2 && !done; p++) begin
      int nf;
      @(negedge clk); ps = ST_ANCHOR; swap = 1'b0; in_valid = 1'b0; #1;
      anchors++;
      if (chk_static && p > 0)
        for (int k = 0; k < N; k++)
          if (dut.mem[k] !== W'(k + 1)) pass_bad++;
      if (hit_i) begin
        if (p != N - 1) pass_bad++;
        done = 1;
      end else begin
        nf = 0;
        do begin
          @(negedge clk); ps = ST_FINDMIN; #1;
          swap = hit_j;
          nf++;
          if (p == abort_pass) begin
            @(posedge clk); #1;
            return;
          end
        end while (!hit_j && nf < N);
        finds += nf;
        if (nf != N - 1 - p) pass_bad++;
      end
    end
    swap = 1'b0;
  endtask

  task automatic run_show(input string tag, input vec_t exp);
    int   nv;
    vec_t got;
    nv = 0;
    got = '{default: '0};
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (nv < N) got[nv] = out_data;
        nv++;
      end
      ps = (c < N) ? ST_SHOW : ST_IDLE;
      #1;
      if (c < N) check({tag, "_end_show"}, 32'(end_show), 32'(c == N - 1));
    end
    check({tag, "_valid_cycles"}, 32'(nv), 32'(N));
    for (int k = 0; k < N; k++) begin
`ifdef SORT_DESCENDING_EN
      check($sformatf("%s_out%0d", tag, k), 32'(got[k]), 32'(exp[N-1-k]));
`else
      check($sformatf("%s_out%0d", tag, k), 32'(got[k]), 32'(exp[k]));
`endif
    end
  endtask

  initial begin
    int   an, fm, bad, nz;
    vec_t d1, e1, d3, e3, d4, d5, e5;
    bit   stat;
    d1 = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    e1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    d3 = '{8'd2, 8'd2, 8'd0, 8'd255, 8'd0, 8'd2, 8'd255, 8'd1};
    e3 = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd255, 8'd255};
    d4 = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    d5 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    e5 = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
`ifdef SORT_DESCENDING_EN
    stat = 1'b0;
`else
    stat = 1'b1;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_flags", 32'({end_load, hit_i, hit_j, end_show}), 32'(0));
    @(negedge clk); rst = 1'b0;

    // Invalid state code: hold everything, flags low
    @(negedge clk); ps = 3'd5; in_valid = 1'b1; in_data = 8'd77; #1;
    check("inv_flags", 32'({end_load, hit_i, hit_j, end_show}), 32'(0));
    @(negedge clk); ps = 3'd7; #1;
    check("inv_ld_cnt", 32'(dut.ld_cnt), 32'(0));
    check("inv_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk); ps = ST_IDLE; in_valid = 1'b0;

    // Test 1/2: basic sort and cycle accounting
    run_load(d1, 1'b0);
    run_sort(-1, 1'b0, an, fm, bad);
    check("t1_anchor_cycles", 32'(an), 32'(8));
    check("t1_findmin_cycles", 32'(fm), 32'(28));
    check("t1_pass_errors", 32'(bad), 32'(0));
    run_show("t1", e1);

    // Test 3: duplicates, extremes, gapped load
    run_load(d3, 1'b1);
    run_sort(-1, 1'b0, an, fm, bad);
    check("t3_findmin_cycles", 32'(fm), 32'(28));
    check("t3_pass_errors", 32'(bad), 32'(0));
    run_show("t3", e3);

    // Test 4: pre-sorted (array must stay unchanged) and reversed
    run_load(e1, 1'b0);
    run_sort(-1, stat, an, fm, bad);
    check("t4a_pass_errors", 32'(bad), 32'(0));
    run_show("t4a", e1);
    run_load(d4, 1'b0);
    run_sort(-1, 1'b0, an, fm, bad);
    check("t4b_pass_errors", 32'(bad), 32'(0));
    run_show("t4b", e1);

    // Test 5: asynchronous reset in the middle of pass i=3
    run_load(d1, 1'b0);
    run_sort(3, 1'b0, an, fm, bad);
    check("t5_pre_i", 32'(dut.i), 32'(3));
    check("t5_pre_j", 32'(dut.j), 32'(5));
    rst = 1'b1; ps = ST_IDLE; swap = 1'b0;
    #1;
    check("t5_counters", 32'({dut.ld_cnt, dut.i, dut.j, dut.min_idx, dut.sh_cnt}), 32'(0));
    nz = 0;
    for (int k = 0; k < N; k++) if (dut.mem[k] !== 8'd0) nz++;
    check("t5_mem_cleared", 32'(nz), 32'(0));
    check("t5_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk); rst = 1'b0;
    run_load(d5, 1'b0);
    run_sort(-1, 1'b0, an, fm, bad);
    check("t5_pass_errors", 32'(bad), 32'(0));
    run_show("t5", e5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Keeps the run bounded even if the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
